// File: rtl/cache_controller.sv
// Miss-handling controller for a 2-way set-associative write-back cache with one LRU bit per set.
// Define CACHE_STATS_EN to add the HitCount/MissCount statistics outputs.
module cache_controller #(
    parameter int DATA_WIDTH        = 32,
    parameter int SET_ADDRESS_WIDTH = 2,
    parameter int TAG_WIDTH         = DATA_WIDTH - SET_ADDRESS_WIDTH - 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic                  Hit0,
    input  logic                  Hit1,
    input  logic                  Valid0,
    input  logic                  Valid1,
    input  logic                  Dirty0,
    input  logic                  Dirty1,
    input  logic [TAG_WIDTH-1:0]  VictimTag,
    input  logic                  MemAck,
    output logic                  Stall,
    output logic                  VictimWay,
    output logic                  SetDirty,
    output logic                  FillWE,
    output logic                  MemReq,
    output logic                  MemWE,
    output logic [DATA_WIDTH-1:0] MemA
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           HitCount,
    output logic [31:0]           MissCount
`endif
);

    localparam int NUM_SETS = 2 ** SET_ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        FILL
    } state_e;

    state_e                       state_q, state_d;
    logic [NUM_SETS-1:0]          lru_q, lru_d;
    logic [SET_ADDRESS_WIDTH-1:0] set_q, set_d;
    logic [TAG_WIDTH-1:0]         tag_q, tag_d;
    logic                         victim_q, victim_d;

    logic [SET_ADDRESS_WIDTH-1:0] reqSet;
    logic [TAG_WIDTH-1:0]         reqTag;
    logic [1:0]                   unusedByteOffset;
    logic                         request;
    logic                         hit;
    logic                         hitWay;
    logic                         missVictim;
    logic                         missNeedsWb;
    logic                         idleHit;
    logic                         idleMiss;

    assign reqSet           = A[SET_ADDRESS_WIDTH+1:2];
    assign reqTag           = A[DATA_WIDTH-1:SET_ADDRESS_WIDTH+2];
    assign unusedByteOffset = A[1:0];

    // A simultaneous read and write is handled as a write; a double hit resolves to way 0.
    assign request  = MemRead | MemWrite;
    assign hit      = Hit0 | Hit1;
    assign hitWay   = ~Hit0;
    assign idleHit  = (state_q == IDLE) & request & hit;
    assign idleMiss = (state_q == IDLE) & request & ~hit;

    // Empty ways are filled before anything is evicted; only a full set consults LRU.
    assign missVictim  = ~Valid0 ? 1'b0 : (~Valid1 ? 1'b1 : lru_q[reqSet]);
    assign missNeedsWb = missVictim ? (Valid1 & Dirty1) : (Valid0 & Dirty0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            lru_q    <= '0;
            set_q    <= '0;
            tag_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lru_q    <= lru_d;
            set_q    <= set_d;
            tag_q    <= tag_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lru_d    = lru_q;
        set_d    = set_q;
        tag_d    = tag_q;
        victim_d = victim_q;
        case (state_q)
            IDLE: begin
                if (request && hit) begin
                    lru_d[reqSet] = ~hitWay;
                end else if (request) begin
                    set_d    = reqSet;
                    tag_d    = reqTag;
                    victim_d = missVictim;
                    state_d  = missNeedsWb ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                if (MemAck) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (MemAck) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                lru_d[set_q] = ~victim_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs are forced low while reset is held, independent of the state register.
    always_comb begin
        Stall     = (state_q != IDLE) | idleMiss;
        VictimWay = 1'b0;
        SetDirty  = 1'b0;
        FillWE    = 1'b0;
        MemReq    = 1'b0;
        MemWE     = 1'b0;
        MemA      = '0;
        if (!RST) begin
            case (state_q)
                IDLE: begin
                    SetDirty = idleHit & MemWrite;
                    if (idleMiss) begin
                        VictimWay = missVictim;
                    end
                end
                WRITEBACK: begin
                    VictimWay = victim_q;
                    MemReq    = 1'b1;
                    MemWE     = 1'b1;
                    MemA      = {VictimTag, set_q, 2'b00};
                end
                REFILL: begin
                    VictimWay = victim_q;
                    MemReq    = 1'b1;
                    MemA      = {tag_q, set_q, 2'b00};
                end
                FILL: begin
                    VictimWay = victim_q;
                    FillWE    = 1'b1;
                end
                default: begin
                    VictimWay = 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hitCount_q, hitCount_d;
    logic [31:0] missCount_q, missCount_d;
    logic        replayWindow_q, replayWindow_d;

    // The hit immediately after FILL is the replay of an already-counted miss.
    assign replayWindow_d = (state_q == FILL);
    assign hitCount_d     = hitCount_q + 32'(idleHit && !replayWindow_q);
    assign missCount_d    = missCount_q + 32'(idleMiss);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hitCount_q     <= '0;
            missCount_q    <= '0;
            replayWindow_q <= 1'b0;
        end else begin
            hitCount_q     <= hitCount_d;
            missCount_q    <= missCount_d;
            replayWindow_q <= replayWindow_d;
        end
    end

    assign HitCount  = hitCount_q;
    assign MissCount = missCount_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a behavioural tag store with LRU drives the status inputs
// and predicts every output cycle by cycle; stats outputs are checked when CACHE_STATS_EN is defined.
module tb_cache_controller;

    localparam logic [37:0] VW_MASK = {6'b000001, 32'h0};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] A = '0;
    logic        Hit0 = 1'b0, Hit1 = 1'b0, Valid0 = 1'b0, Valid1 = 1'b0;
    logic        Dirty0 = 1'b0, Dirty1 = 1'b0;
    logic [27:0] VictimTag = '0;
    logic        MemAck = 1'b0;
    logic        Stall, VictimWay, SetDirty, FillWE, MemReq, MemWE;
    logic [31:0] MemA;
`ifdef CACHE_STATS_EN
    logic [31:0] HitCount, MissCount;
`endif

    cache_controller dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .A(A),
        .Hit0(Hit0), .Hit1(Hit1), .Valid0(Valid0), .Valid1(Valid1),
        .Dirty0(Dirty0), .Dirty1(Dirty1), .VictimTag(VictimTag), .MemAck(MemAck),
        .Stall(Stall), .VictimWay(VictimWay), .SetDirty(SetDirty), .FillWE(FillWE),
        .MemReq(MemReq), .MemWE(MemWE), .MemA(MemA)
`ifdef CACHE_STATS_EN
        , .HitCount(HitCount), .MissCount(MissCount)
`endif
    );

    always #5 CLK = ~CLK;

    // Bit order: Stall, MemReq, MemWE, FillWE, SetDirty, VictimWay, MemA.
    wire [37:0] outBus = {Stall, MemReq, MemWE, FillWE, SetDirty, VictimWay, MemA};

    int          errors = 0;
    int          checks = 0;
    logic [27:0] tagS   [4][2];
    bit          validS [4][2];
    bit          dirtyS [4][2];
    bit          lruM   [4];
    int          hitsM  = 0;
    int          missesM = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit modelVictim(input logic [1:0] s);
        if (!validS[s][0]) return 1'b0;
        if (!validS[s][1]) return 1'b1;
        return lruM[s];
    endfunction

    task automatic driveStatus(input logic [31:0] addr);
        logic [1:0]  s;
        logic [27:0] t;
        s = addr[3:2];
        t = addr[31:4];
        Hit0      = validS[s][0] && (tagS[s][0] == t);
        Hit1      = validS[s][1] && (tagS[s][1] == t);
        Valid0    = validS[s][0];
        Valid1    = validS[s][1];
        Dirty0    = dirtyS[s][0];
        Dirty1    = dirtyS[s][1];
        VictimTag = tagS[s][modelVictim(s)];
    endtask

    task automatic clearStore();
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                tagS[s][w]   = '0;
                validS[s][w] = 1'b0;
                dirtyS[s][w] = 1'b0;
            end
        end
    endtask

    task automatic doReset();
        RST = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; MemAck = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        for (int s = 0; s < 4; s++) lruM[s] = 1'b0;
        hitsM = 0;
        missesM = 0;
    endtask

    // rw: 0 read, 1 write, 2 read+write. One full transaction including miss handling and replay.
    task automatic doAccess(input logic [31:0] addr, input int rw, input int wbDelay,
                            input int rfDelay, input bit dropReq, input bit ackNoise);
        logic [1:0]  s;
        logic [27:0] t, vt;
        logic [37:0] exp;
        bit          isWr, h0, h1, v, wb;
        s    = addr[3:2];
        t    = addr[31:4];
        isWr = (rw != 0);
        MemRead  = (rw != 1);
        MemWrite = isWr;
        A        = addr;
        driveStatus(addr);
        h0 = validS[s][0] && (tagS[s][0] == t);
        h1 = validS[s][1] && (tagS[s][1] == t);
        MemAck = ackNoise;
        if (h0 || h1) begin
            v = h0 ? 1'b0 : 1'b1;
            @(negedge CLK);
            exp = {1'b0, 1'b0, 1'b0, 1'b0, isWr, 1'b0, 32'h0};
            checks++;
            if ((outBus | VW_MASK) !== (exp | VW_MASK)) begin
                errors++;
                $display("[TB] FAIL hit A=%h: outputs=%h expected=%h", addr, outBus, exp);
            end
            tick();
            lruM[s] = ~v;
            if (isWr) dirtyS[s][v] = 1'b1;
            hitsM++;
        end else begin
            v  = modelVictim(s);
            wb = validS[s][v] && dirtyS[s][v];
            vt = tagS[s][v];
            @(negedge CLK);
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v, 32'h0};
            checks++;
            if (outBus !== exp) begin
                errors++;
                $display("[TB] FAIL miss-detect A=%h: outputs=%h expected=%h", addr, outBus, exp);
            end
            tick();
            missesM++;
            if (dropReq) begin
                MemRead = 1'b0;
                MemWrite = 1'b0;
            end
            if (wb) begin
                for (int i = 0; i <= wbDelay; i++) begin
                    MemAck = (i == wbDelay);
                    @(negedge CLK);
                    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, v, vt, s, 2'b00};
                    checks++;
                    if (outBus !== exp) begin
                        errors++;
                        $display("[TB] FAIL writeback A=%h: outputs=%h expected=%h", addr, outBus, exp);
                    end
                    tick();
                end
            end
            for (int i = 0; i <= rfDelay; i++) begin
                MemAck = (i == rfDelay);
                @(negedge CLK);
                exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v, t, s, 2'b00};
                checks++;
                if (outBus !== exp) begin
                    errors++;
                    $display("[TB] FAIL refill A=%h: outputs=%h expected=%h", addr, outBus, exp);
                end
                tick();
            end
            MemAck = ackNoise;
            @(negedge CLK);
            exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, v, 32'h0};
            checks++;
            if (outBus !== exp) begin
                errors++;
                $display("[TB] FAIL fill A=%h: outputs=%h expected=%h", addr, outBus, exp);
            end
            tick();
            MemAck = 1'b0;
            tagS[s][v]   = t;
            validS[s][v] = 1'b1;
            dirtyS[s][v] = 1'b0;
            lruM[s]      = ~v;
            driveStatus(addr);
            @(negedge CLK);
            exp = {1'b0, 1'b0, 1'b0, 1'b0, isWr && !dropReq, 1'b0, 32'h0};
            checks++;
            if ((outBus | VW_MASK) !== (exp | VW_MASK)) begin
                errors++;
                $display("[TB] FAIL after-fill A=%h: outputs=%h expected=%h", addr, outBus, exp);
            end
            tick();
            if (!dropReq) begin
                lruM[s] = ~v;
                if (isWr) dirtyS[s][v] = 1'b1;
            end
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemAck   = 1'b0;
    endtask

    task automatic test_reset();
        logic [37:0] exp;
        RST = 1'b1;
        MemWrite = 1'b1; A = 32'h10; Hit0 = 1'b1; Valid0 = 1'b1; Valid1 = 1'b1;
        Dirty0 = 1'b1; Dirty1 = 1'b1; VictimTag = '1; MemAck = 1'b1;
        @(negedge CLK);
        exp = '0;
        checks++;
        if (outBus !== exp) begin
            errors++;
            $display("[TB] FAIL reset-hit: outputs=%h expected=%h", outBus, exp);
        end
        Hit0 = 1'b0;
        #1;
        exp = {1'b1, 37'h0};
        checks++;
        if (outBus !== exp) begin
            errors++;
            $display("[TB] FAIL reset-miss: outputs=%h expected=%h", outBus, exp);
        end
        MemWrite = 1'b0; MemAck = 1'b0;
        doReset();
        clearStore();
        @(negedge CLK);
        checks++;
        if ((outBus | VW_MASK) !== VW_MASK) begin
            errors++;
            $display("[TB] FAIL reset-idle: outputs=%h expected=%h", outBus, 38'h0);
        end
`ifdef CACHE_STATS_EN
        checks++;
        if ({HitCount, MissCount} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset-stats: hit=%0d miss=%0d expected 0 0", HitCount, MissCount);
        end
`endif
        tick();
    endtask

    task automatic test_spec_sequence();
        tagS[0][0] = 28'h1; validS[0][0] = 1'b1;
        tagS[0][1] = 28'h5; validS[0][1] = 1'b1; dirtyS[0][1] = 1'b1;
        doAccess(32'h10, 0, 0, 0, 1'b0, 1'b0);
        doAccess(32'h24, 0, 0, 2, 1'b0, 1'b0);
        doAccess(32'h30, 1, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_dual_hit();
        tagS[2][0] = 28'h7; validS[2][0] = 1'b1; dirtyS[2][0] = 1'b0;
        tagS[2][1] = 28'h7; validS[2][1] = 1'b1; dirtyS[2][1] = 1'b0;
        doAccess(32'h78, 2, 0, 0, 1'b0, 1'b1);
        doAccess(32'h88, 0, 0, 1, 1'b0, 1'b0);
        doAccess(32'h78, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abandon_request();
        doAccess(32'hA0, 0, 0, 1, 1'b1, 1'b0);
        doAccess(32'hB0, 1, 2, 1, 1'b1, 1'b1);
        doAccess(32'hB0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_refill();
        logic [37:0] exp;
        MemRead = 1'b1;
        A = 32'h334;
        driveStatus(32'h334);
        tick();
        @(negedge CLK);
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, modelVictim(2'd1), 32'h334};
        checks++;
        if (outBus !== exp) begin
            errors++;
            $display("[TB] FAIL pre-reset-refill: outputs=%h expected=%h", outBus, exp);
        end
        RST = 1'b1;
        MemRead = 1'b0;
        #1;
        checks++;
        if (outBus !== 38'h0) begin
            errors++;
            $display("[TB] FAIL reset-abort: outputs=%h expected=%h", outBus, 38'h0);
        end
        MemAck = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (outBus !== 38'h0) begin
                errors++;
                $display("[TB] FAIL reset-hold: outputs=%h expected=%h", outBus, 38'h0);
            end
        end
        tick();
        RST = 1'b0;
        MemAck = 1'b0;
        for (int s = 0; s < 4; s++) lruM[s] = 1'b0;
        hitsM = 0;
        missesM = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ((outBus | VW_MASK) !== VW_MASK) begin
                errors++;
                $display("[TB] FAIL post-reset-idle: outputs=%h expected=%h", outBus, 38'h0);
            end
            tick();
        end
        doAccess(32'h334, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        doReset();
        clearStore();
        for (int n = 0; n < 80; n++) begin
            addr = {28'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            doAccess(addr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'($urandom));
        end
`ifdef CACHE_STATS_EN
        @(negedge CLK);
        checks++;
        if ({HitCount, MissCount} !== {32'(hitsM), 32'(missesM)}) begin
            errors++;
            $display("[TB] FAIL random-stats: hit=%0d miss=%0d expected %0d %0d", HitCount, MissCount, hitsM, missesM);
        end
        tick();
`endif
    endtask

    task automatic test_stats();
        doReset();
        clearStore();
        tagS[3][0] = 28'h2; validS[3][0] = 1'b1;
        doAccess(32'h2C, 0, 0, 0, 1'b0, 1'b0);
        doAccess(32'h2C, 1, 0, 0, 1'b0, 1'b0);
        doAccess(32'h2C, 0, 0, 0, 1'b0, 1'b0);
        doAccess(32'h9C, 0, 0, 1, 1'b0, 1'b0);
`ifdef CACHE_STATS_EN
        @(negedge CLK);
        checks++;
        if ({HitCount, MissCount} !== {32'd3, 32'd1}) begin
            errors++;
            $display("[TB] FAIL stats-3hit-1miss: hit=%0d miss=%0d expected 3 1", HitCount, MissCount);
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_spec_sequence();
        test_dual_hit();
        test_abandon_request();
        test_reset_mid_refill();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter DATA_WIDTH, 32, address/data width.
REQ-002 Parameter SET_ADDRESS_WIDTH, 2, set index bits (2**SET_ADDRESS_WIDTH sets).
REQ-003 Parameter TAG_WIDTH, DATA_WIDTH-SET_ADDRESS_WIDTH-2, tag bits.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 RST  in  1  async active-high reset.
REQ-007 MemRead / MemWrite  in  1 each  CPU access request.
REQ-008 A  in  DATA_WIDTH  CPU byte address; tag=A[DW-1:SAW+2], set=A[SAW+1:2].
REQ-009 Hit0 / Hit1  in  1 each  tag match with valid bit, per way, indexed set.
REQ-010 Valid0 / Valid1 / Dirty0 / Dirty1  in  1 each  per-way status, indexed set.
REQ-011 VictimTag  in  TAG_WIDTH  tag stored in way VictimWay of indexed set.
REQ-012 MemAck  in  1  main-memory transfer complete, one-cycle pulse.
REQ-013 Stall  out  1  CPU must hold request and address.
REQ-014 VictimWay  out  1  way selected for writeback/fill.
REQ-015 SetDirty  out  1  mark hit way dirty (write hit).
REQ-016 FillWE  out  1  write refill data and tag into VictimWay, V=1, D=0.
REQ-017 MemReq / MemWE  out  1 each  memory request / write-not-read.
REQ-018 MemA  out  DATA_WIDTH  word-aligned memory address.

Function
REQ-019 States SHALL be IDLE, WRITEBACK, REFILL, FILL; encoding free.
REQ-020 Request = MemRead|MemWrite; both asserted SHALL be treated as write.
REQ-021 Hit = Hit0|Hit1; both set SHALL resolve to way 0.
REQ-022 Stall SHALL equal (state!=IDLE) | (IDLE & request & ~Hit), combinational.
REQ-023 IDLE hit: serviced same cycle, no Stall; write hit SHALL pulse SetDirty for hit way.
REQ-024 IDLE miss: latch set, tag, victim; victim = way0 if ~Valid0, else way1 if ~Valid1, else LRU[set].
REQ-025 IDLE miss -> WRITEBACK if victim Valid and Dirty, else -> REFILL.
REQ-026 WRITEBACK: MemReq=1, MemWE=1, MemA={VictimTag,set,2'b00}; on MemAck -> REFILL.
REQ-027 REFILL: MemReq=1, MemWE=0, MemA={latched tag,set,2'b00}; on MemAck -> FILL.
REQ-028 FILL: one cycle, FillWE=1, MemReq=0 -> IDLE; replayed access then hits.
REQ-029 VictimWay SHALL be held constant from miss detection through FILL.
REQ-030 LRU: one bit per set; hit or fill of way w SHALL set LRU[set] <= ~w at clock edge.
REQ-031 MemAck outside WRITEBACK/REFILL SHALL be ignored.
REQ-032 Request deasserted mid-miss: sequence SHALL still complete to IDLE.
REQ-033 MemA, MemWE SHALL be 0 when MemReq=0.

Reset
REQ-034 RST SHALL force IDLE asynchronously; MemReq, MemWE, FillWE, SetDirty, VictimWay, MemA SHALL read 0 while RST high.
REQ-035 RST SHALL clear all LRU bits and latched set/tag; reset mid-transfer SHALL abandon it (no partial fill).

Configuration
REQ-036 Macro CACHE_STATS_EN defined: outputs HitCount, MissCount (32 bits each) added.
REQ-037 HitCount +1 per IDLE hit excluding the first post-FILL replay; MissCount +1 per miss leaving IDLE; both wrap at 2**32, clear on RST.
REQ-038 Macro undefined: ports and counters absent, all other behaviour identical.

Verification
REQ-039 Reset, read A=0x10 Hit0=1 -> Stall=0 whole cycle, LRU[0]=1, MemReq never set.
REQ-040 Read miss A=0x24, Valid0=0 -> Stall, REFILL MemA=0x24 MemWE=0, MemAck after 3 cycles -> FILL FillWE=1 VictimWay=0 -> IDLE.
REQ-041 Write miss A=0x30, both valid, LRU[0]=1, Dirty1=1, VictimTag=0x5 -> WRITEBACK MemA=0x50 MemWE=1, then REFILL MemA=0x30, FILL way1.
REQ-042 Write hit Hit1=1 -> SetDirty=1 one cycle, VictimWay irrelevant, Stall=0.
REQ-043 RST asserted during REFILL with MemReq=1 -> MemReq=0 same cycle, FillWE never pulses, state IDLE.
REQ-044 CACHE_STATS_EN: 3 hits + 1 miss (with replay) -> HitCount=3, MissCount=1.
